// File: rtl/vga_scan.sv
// VGA raster scanner: pixel-rate col/row to the renderer, then blanked RGB with
// hsync/vsync lagging col/row by one pixel, plus a one-clock frame_start pulse.
module vga_scan #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(PIX_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYN_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYN_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYN_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYN_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  logic [DW-1:0] r_div;
  logic [9:0]    r_h_cnt;
  logic [9:0]    r_v_cnt;
  logic          r_act1;
  logic          r_hs1;
  logic          r_vs1;

  logic w_pix_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_act;
  logic w_hs_on;
  logic w_vs_on;

  assign w_pix_tick = (r_div == DIV_LAST);
  assign w_h_last   = (r_h_cnt == H_LAST);
  assign w_v_last   = (r_v_cnt == V_LAST);
  assign w_act      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_on    = (r_h_cnt >= H_SYN_ON) && (r_h_cnt < H_SYN_OFF);
  assign w_vs_on    = (r_v_cnt >= V_SYN_ON) && (r_v_cnt < V_SYN_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_act1      <= 1'b0;
      r_hs1       <= ~HS_ON;
      r_vs1       <= ~VS_ON;
      col         <= '0;
      row         <= '0;
      hs          <= ~HS_ON;
      vs          <= ~VS_ON;
      de          <= 1'b0;
      {r, g, b}   <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (w_pix_tick) begin
        r_div <= '0;
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
        // Stage 1: coordinates and timing flags for the pixel being issued.
        col    <= r_h_cnt;
        row    <= r_v_cnt;
        r_act1 <= w_act;
        r_hs1  <= w_hs_on ? HS_ON : ~HS_ON;
        r_vs1  <= w_vs_on ? VS_ON : ~VS_ON;
        // Stage 2: renderer colour for the previous pixel, blanked outside active.
        de        <= r_act1;
        {r, g, b} <= r_act1 ? rgb_in : 12'h000;
        hs        <= r_hs1;
        vs        <= r_vs1;
        frame_start <= w_h_last && w_v_last;
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: three instances (full 640x480 geometry, and a shrunken
// geometry at PIX_DIV 4 and 2) checked every clock against a scoreboard model.
module tb_vga_scan;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rgb0, rgb1, rgb2;
  logic [9:0]  o_col [3];
  logic [9:0]  o_row [3];
  logic        o_hs  [3];
  logic        o_vs  [3];
  logic        o_de  [3];
  logic [3:0]  o_r   [3];
  logic [3:0]  o_g   [3];
  logic [3:0]  o_b   [3];
  logic        o_fs  [3];

  always #5 clk = ~clk;

  assign rgb0 = {2'b00, o_col[0]};
  assign rgb1 = 12'hFFF;

  vga_scan u_full (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb0), .col(o_col[0]), .row(o_row[0]),
    .hs(o_hs[0]), .vs(o_vs[0]), .de(o_de[0]), .r(o_r[0]), .g(o_g[0]), .b(o_b[0]),
    .frame_start(o_fs[0])
  );

  vga_scan #(
    .PIX_DIV(4), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_s4 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb1), .col(o_col[1]), .row(o_row[1]),
    .hs(o_hs[1]), .vs(o_vs[1]), .de(o_de[1]), .r(o_r[1]), .g(o_g[1]), .b(o_b[1]),
    .frame_start(o_fs[1])
  );

  vga_scan #(
    .PIX_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_s2 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb2), .col(o_col[2]), .row(o_row[2]),
    .hs(o_hs[2]), .vs(o_vs[2]), .de(o_de[2]), .r(o_r[2]), .g(o_g[2]), .b(o_b[2]),
    .frame_start(o_fs[2])
  );

  function automatic int pd(int k);  return (k == 2) ? 2 : 4;      endfunction
  function automatic int ha(int k);  return (k == 0) ? 640 : 16;   endfunction
  function automatic int hf(int k);  return (k == 0) ? 16 : 4;     endfunction
  function automatic int hw(int k);  return (k == 0) ? 96 : 6;     endfunction
  function automatic int ht(int k);  return (k == 0) ? 800 : 32;   endfunction
  function automatic int va(int k);  return (k == 0) ? 480 : 8;    endfunction
  function automatic int vf(int k);  return (k == 0) ? 10 : 2;     endfunction
  function automatic int vw(int k);  return 2;                     endfunction
  function automatic int vt(int k);  return (k == 0) ? 525 : 15;   endfunction

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check_val(input string tag, input int k, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%0h exp=%0h cyc=%0d", tag, k, got, exp, cyc);
    end
  endtask

  int         m_div [3];
  int         m_h   [3];
  int         m_v   [3];
  logic [9:0] e_col [3];
  logic [9:0] e_row [3];
  logic       e_fs  [3];
  pix_t       e_pix [3];
  pix_t       q0[$], q1[$], q2[$];

  function automatic pix_t idle_pix();
    pix_t p;
    p.de = 1'b0; p.hs = 1'b1; p.vs = 1'b1; p.rgb = 12'h000;
    return p;
  endfunction

  task automatic model_reset(input int k);
    m_div[k] = 0; m_h[k] = 0; m_v[k] = 0;
    e_col[k] = '0; e_row[k] = '0; e_fs[k] = 1'b0;
    e_pix[k] = idle_pix();
    case (k)
      0: begin q0.delete(); q0.push_back(idle_pix()); end
      1: begin q1.delete(); q1.push_back(idle_pix()); end
      default: begin q2.delete(); q2.push_back(idle_pix()); end
    endcase
  endtask

  // Expected pin values for the pixel just issued are queued and popped one tick later.
  task automatic model_step(input int k);
    pix_t        nx;
    logic [11:0] stim;
    e_fs[k] = 1'b0;
    if (m_div[k] == pd(k) - 1) begin
      m_div[k] = 0;
      e_col[k] = m_h[k][9:0];
      e_row[k] = m_v[k][9:0];
      e_fs[k]  = (m_h[k] == ht(k) - 1) && (m_v[k] == vt(k) - 1);
      nx.de = (m_h[k] < ha(k)) && (m_v[k] < va(k));
      nx.hs = (m_h[k] >= ha(k) + hf(k) && m_h[k] < ha(k) + hf(k) + hw(k)) ? 1'b0 : 1'b1;
      nx.vs = (m_v[k] >= va(k) + vf(k) && m_v[k] < va(k) + vf(k) + vw(k)) ? 1'b0 : 1'b1;
      case (k)
        0: stim = {2'b00, m_h[k][9:0]};
        1: stim = 12'hFFF;
        default: begin stim = 12'($urandom); rgb2 = stim; end
      endcase
      nx.rgb = nx.de ? stim : 12'h000;
      case (k)
        0: begin e_pix[k] = q0.pop_front(); q0.push_back(nx); end
        1: begin e_pix[k] = q1.pop_front(); q1.push_back(nx); end
        default: begin e_pix[k] = q2.pop_front(); q2.push_back(nx); end
      endcase
      if (m_h[k] == ht(k) - 1) begin
        m_h[k] = 0;
        m_v[k] = (m_v[k] == vt(k) - 1) ? 0 : m_v[k] + 1;
      end else begin
        m_h[k] = m_h[k] + 1;
      end
    end else begin
      m_div[k] = m_div[k] + 1;
    end
  endtask

  task automatic compare_all(input int k);
    check_val("col", k, 32'(o_col[k]), 32'(e_col[k]));
    check_val("row", k, 32'(o_row[k]), 32'(e_row[k]));
    check_val("de", k, 32'(o_de[k]), 32'(e_pix[k].de));
    check_val("hs", k, 32'(o_hs[k]), 32'(e_pix[k].hs));
    check_val("vs", k, 32'(o_vs[k]), 32'(e_pix[k].vs));
    check_val("rgb", k, 32'({o_r[k], o_g[k], o_b[k]}), 32'(e_pix[k].rgb));
    check_val("frame_start", k, 32'(o_fs[k]), 32'(e_fs[k]));
  endtask

  // Interval measurements on the live pins.
  int         t_hfall = 0, t_col656 = 0, hs_per = 0, hs_low = 0, hs_lag = 0;
  int         t_fs [3], fs_per [3], t_vfall [3], vs_low [3];
  logic       p_hs0 = 1'b1;
  logic       p_vs [3];
  logic [9:0] p_col0 = '0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      t_fs[k] = 0; fs_per[k] = 0; t_vfall[k] = 0; vs_low[k] = 0; p_vs[k] = 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) model_reset(k);
      else model_step(k);
      compare_all(k);
    end
    if (!rst_n) begin
      t_hfall = 0; t_col656 = 0;
      for (int k = 0; k < 3; k++) begin t_fs[k] = 0; t_vfall[k] = 0; end
    end else begin
      if (o_col[0] == 10'd656 && p_col0 != 10'd656) t_col656 = cyc;
      if (p_hs0 && !o_hs[0]) begin
        if (t_hfall > 0) hs_per = cyc - t_hfall;
        if (t_col656 > 0) hs_lag = cyc - t_col656;
        t_hfall = cyc;
      end
      if (!p_hs0 && o_hs[0] && t_hfall > 0) hs_low = cyc - t_hfall;
      for (int k = 1; k < 3; k++) begin
        if (o_fs[k]) begin
          if (t_fs[k] > 0) fs_per[k] = cyc - t_fs[k];
          t_fs[k] = cyc;
        end
        if (p_vs[k] && !o_vs[k]) t_vfall[k] = cyc;
        if (!p_vs[k] && o_vs[k] && t_vfall[k] > 0) vs_low[k] = cyc - t_vfall[k];
      end
    end
    p_hs0  = o_hs[0];
    p_col0 = o_col[0];
    for (int k = 1; k < 3; k++) p_vs[k] = o_vs[k];
  end

  initial begin
    rgb2  = 12'h000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (1000) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val("async_col", k, 32'(o_col[k]), 32'd0);
      check_val("async_row", k, 32'(o_row[k]), 32'd0);
      check_val("async_hs", k, 32'(o_hs[k]), 32'd1);
      check_val("async_vs", k, 32'(o_vs[k]), 32'd1);
      check_val("async_de", k, 32'(o_de[k]), 32'd0);
      check_val("async_rgb", k, 32'({o_r[k], o_g[k], o_b[k]}), 32'd0);
      check_val("async_fs", k, 32'(o_fs[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (7000) @(negedge clk);
    #1;
    check_val("hs_period", 0, 32'(hs_per), 32'd3200);
    check_val("hs_low", 0, 32'(hs_low), 32'd384);
    check_val("hs_lag", 0, 32'(hs_lag), 32'd4);
    check_val("fs_period", 1, 32'(fs_per[1]), 32'd1920);
    check_val("fs_period", 2, 32'(fs_per[2]), 32'd960);
    check_val("vs_low", 1, 32'(vs_low[1]), 32'd256);
    check_val("vs_low", 2, 32'(vs_low[2]), 32'd128);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
